// File: rtl/pcie_wrap0_master_0_bytes_to_packets.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pcie_wrap0_master_0_bytes_to_packets                            |
// | Purpose  : Decodes the escaped host byte stream into Avalon-ST packets.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pcie_wrap0_master_0_bytes_to_packets #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel
);

  localparam logic [7:0] c_sop  = 8'h7A;
  localparam logic [7:0] c_eop  = 8'h7B;
  localparam logic [7:0] c_chan = 8'h7C;
  localparam logic [7:0] c_esc  = 8'h7D;
  localparam logic [7:0] c_xor  = 8'h20;

  logic                     r_esc_pending;
  logic                     r_chan_pending;
  logic                     r_sop_pending;
  logic                     r_eop_pending;
  logic [CHANNEL_WIDTH-1:0] r_chan;

  logic                     w_accept;
  logic                     w_emit;
  logic                     w_load_chan;
  logic                     w_set_esc;
  logic                     w_clr_esc;
  logic                     w_set_sop;
  logic                     w_set_eop;
  logic                     w_set_chan;
  logic                     w_clr_chan;
  logic [7:0]               w_byte;
  logic [CHANNEL_WIDTH-1:0] w_chan_next;

  // The output register doubles as the only buffer: a byte can enter whenever
  // the held byte is empty or leaving this cycle.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_emit      = 1'b0;
    w_load_chan = 1'b0;
    w_set_esc   = 1'b0;
    w_clr_esc   = 1'b0;
    w_set_sop   = 1'b0;
    w_set_eop   = 1'b0;
    w_set_chan  = 1'b0;
    w_clr_chan  = 1'b0;
    w_byte      = in_data;
    if (r_esc_pending) begin
      w_clr_esc = 1'b1;
      w_byte    = in_data ^ c_xor;
      if (r_chan_pending) begin
        w_load_chan = 1'b1;
        w_clr_chan  = 1'b1;
      end else begin
        w_emit = 1'b1;
      end
    end else begin
      case (in_data)
        c_esc:  w_set_esc = 1'b1;
        c_sop: begin
          w_set_sop  = 1'b1;
          w_clr_chan = 1'b1;
        end
        c_eop: begin
          w_set_eop  = 1'b1;
          w_clr_chan = 1'b1;
        end
        c_chan: w_set_chan = 1'b1;
        default: begin
          if (r_chan_pending) begin
            w_load_chan = 1'b1;
            w_clr_chan  = 1'b1;
          end else begin
            w_emit = 1'b1;
          end
        end
      endcase
    end
  end

  // The channel byte is truncated (or zero-extended) to the channel width.
  generate
    if (CHANNEL_WIDTH <= 8) begin : g_chan_narrow
      assign w_chan_next = w_byte[CHANNEL_WIDTH-1:0];
    end else begin : g_chan_wide
      assign w_chan_next = {{(CHANNEL_WIDTH-8){1'b0}}, w_byte};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_esc_pending     <= 1'b0;
      r_chan_pending    <= 1'b0;
      r_sop_pending     <= 1'b0;
      r_eop_pending     <= 1'b0;
      r_chan            <= '0;
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
    end else begin
      if (w_accept) begin
        if (w_set_esc) begin
          r_esc_pending <= 1'b1;
        end else if (w_clr_esc) begin
          r_esc_pending <= 1'b0;
        end
        if (w_set_chan) begin
          r_chan_pending <= 1'b1;
        end else if (w_clr_chan) begin
          r_chan_pending <= 1'b0;
        end
        if (w_load_chan) begin
          r_chan <= w_chan_next;
        end
        if (w_emit) begin
          out_data          <= w_byte;
          out_startofpacket <= r_sop_pending;
          out_endofpacket   <= r_eop_pending;
          out_channel       <= r_chan;
          r_sop_pending     <= 1'b0;
          r_eop_pending     <= 1'b0;
        end else begin
          if (w_set_sop) begin
            r_sop_pending <= 1'b1;
          end
          if (w_set_eop) begin
            r_eop_pending <= 1'b1;
          end
        end
      end
      if (w_accept && w_emit) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcie_wrap0_master_0_bytes_to_packets.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pcie_wrap0_master_0_bytes_to_packets                         |
// | Purpose  : Vector table, corner sequences and randomized model checking.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pcie_wrap0_master_0_bytes_to_packets;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;

  int n_vec = 0;
  int n_mis = 0;

  pcie_wrap0_master_0_bytes_to_packets #(.CHANNEL_WIDTH(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic       ee;
    logic [7:0] ec;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic [7:0] c;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  // Reference decoder state: a direct reading of the byte-stream rules.
  logic       m_esc, m_chp, m_sop, m_eop;
  logic [7:0] m_ch;

  function automatic void model_reset();
    m_esc = 0; m_chp = 0; m_sop = 0; m_eop = 0; m_ch = 8'h00;
    exp_q.delete();
  endfunction

  function automatic void model_emit(input logic [7:0] b);
    exp_t x;
    x.d = b; x.s = m_sop; x.e = m_eop; x.c = m_ch;
    exp_q.push_back(x);
    m_sop = 0; m_eop = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] d);
    logic [7:0] lit;
    if (m_esc) begin
      m_esc = 0;
      lit = d ^ 8'h20;
      if (m_chp) begin m_ch = lit; m_chp = 0; end
      else model_emit(lit);
    end else if (d == 8'h7D) m_esc = 1;
    else if (d == 8'h7A) begin m_sop = 1; m_chp = 0; end
    else if (d == 8'h7B) begin m_eop = 1; m_chp = 0; end
    else if (d == 8'h7C) m_chp = 1;
    else if (m_chp) begin m_ch = d; m_chp = 0; end
    else model_emit(d);
  endfunction

  task automatic check_out(input string name, input logic ev, input logic [7:0] ed,
                           input logic es, input logic ee, input logic [7:0] ec);
    n_vec++;
    if (out_valid !== ev || (ev && (out_data !== ed || out_startofpacket !== es ||
        out_endofpacket !== ee || out_channel !== ec))) begin
      n_mis++;
      $display("FAIL %s: got v=%0b d=%02h sop=%0b eop=%0b ch=%02h, expected v=%0b d=%02h sop=%0b eop=%0b ch=%02h",
               name, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel,
               ev, ed, es, ee, ec);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy, input logic ev,
                     input logic [7:0] ed, input logic es, input logic ee, input logic [7:0] ec);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ev = ev; v.ed = ed; v.es = es; v.ee = ee; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic pulse_reset();
    in_valid = 0;
    reset_n  = 0;
    step();
    reset_n  = 1;
    #1;
  endtask

  initial begin
    exp_t       x;
    logic [7:0] b;
    logic       hs;
    logic       hold_prev;
    logic [7:0] prev_d, prev_c;
    logic       prev_s, prev_e;
    int         accepted;
    int         cycles;

    reset_n = 0; in_valid = 0; in_data = 8'h00; out_ready = 1;
    #2;
    check_val("in_ready_in_reset", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    #1;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_flags", {out_startofpacket, out_endofpacket}, 0);
    check_val("rst_chan", out_channel, 0);

    // Stream 1: SOP, channel 3, data, EOP
    add(1, 8'h7A, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7C, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h03, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h11, 1, 1, 8'h11, 1, 0, 8'h03);
    add(1, 8'h22, 1, 1, 8'h22, 0, 0, 8'h03);
    add(1, 8'h7B, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h33, 1, 1, 8'h33, 0, 1, 8'h03);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);
    // Stream 2: escaped specials as payload
    add(1, 8'h7A, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7D, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h5A, 1, 1, 8'h7A, 1, 0, 8'h03);
    add(1, 8'h7B, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7D, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h5D, 1, 1, 8'h7D, 0, 1, 8'h03);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);
    // Stream 3: escaped channel value, then a cancelled channel capture
    add(1, 8'h7C, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7D, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h5C, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h44, 1, 1, 8'h44, 0, 0, 8'h7C);
    add(1, 8'h7C, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7A, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h55, 1, 1, 8'h55, 1, 0, 8'h7C);
    add(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      step();
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ee, tbl[i].ec);
    end

    // Backpressure: held byte stays put, pending byte waits, no loss or duplication
    in_valid = 1; in_data = 8'h11; out_ready = 1;
    step();
    check_out("bp_first", 1, 8'h11, 0, 0, 8'h7C);
    in_data = 8'h22; out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_out("bp_hold", 1, 8'h11, 0, 0, 8'h7C);
      check_val("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    step();
    check_out("bp_release", 1, 8'h22, 0, 0, 8'h7C);
    in_valid = 0;
    step();
    check_out("bp_drain", 0, 8'h00, 0, 0, 8'h00);

    // Asynchronous reset clears a held output immediately
    in_valid = 1; in_data = 8'h66; out_ready = 0;
    step();
    check_out("pre_async", 1, 8'h66, 0, 0, 8'h7C);
    in_valid = 0;
    #2 reset_n = 0;
    #1;
    check_val("async_valid", out_valid, 0);
    check_val("async_data", out_data, 0);
    check_val("async_chan", out_channel, 0);
    check_val("async_in_ready", in_ready, 1);
    step();
    reset_n = 1; out_ready = 1;

    // Reset mid-escape: dangling CHANNEL+ESC state must not survive
    in_valid = 1; in_data = 8'h7C;
    step();
    in_data = 8'h7D;
    step();
    pulse_reset();
    in_valid = 1; in_data = 8'h5A;
    step();
    check_out("post_reset", 1, 8'h5A, 0, 0, 8'h00);
    in_valid = 0;
    step();

    // Back-to-back non-special bytes at one per cycle
    pulse_reset();
    for (int k = 0; k < 16; k++) begin
      do b = 8'($urandom); while (b >= 8'h7A && b <= 8'h7D);
      in_valid = 1; in_data = b; out_ready = 1;
      step();
      check_out("burst", 1, b, 0, 0, 8'h00);
    end
    in_valid = 0;
    step();

    // Randomized run against the reference decoder
    pulse_reset();
    model_reset();
    accepted = 0; cycles = 0; hold_prev = 0;
    prev_d = 0; prev_s = 0; prev_e = 0; prev_c = 0;
    while (accepted < 10000 && cycles < 40000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = ($urandom_range(0, 4) == 0) ? 8'(8'h7A + $urandom_range(0, 3)) : 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (hold_prev)
        check_out("rand_hold", 1, prev_d, prev_s, prev_e, prev_c);
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL rand_extra: got d=%02h, expected no output", out_data);
        end else begin
          x = exp_q.pop_front();
          check_out("rand", 1, x.d, x.s, x.e, x.c);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_d = out_data; prev_s = out_startofpacket; prev_e = out_endofpacket; prev_c = out_channel;
      if (in_valid && in_ready) begin
        model_byte(in_data);
        accepted++;
      end
      step();
      cycles++;
    end
    check_val("rand_budget", (accepted >= 10000), 1);
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL drain_extra: got d=%02h, expected no output", out_data);
        end else begin
          x = exp_q.pop_front();
          check_out("drain", 1, x.d, x.s, x.e, x.c);
        end
      end
      step();
    end
    check_val("rand_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
